// File: rtl/sdram_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sdram_arb_pkg
//  Purpose  : Shared types and round-robin select helper for the SDRAM arbiter
//  Revision : 1.0 - initial release
// ============================================================================
package sdram_arb_pkg;

    localparam int C_ADDR_W    = 25;
    localparam int C_DATA_W    = 32;
    localparam int C_BE_W      = C_DATA_W / 8;
    localparam int C_MAX_PORTS = 8;
    localparam int C_PORT_ID_W = $clog2(C_MAX_PORTS);

    // Sized for the largest legal port count so one type serves every build
    typedef logic [C_PORT_ID_W-1:0] port_id_t;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_OWN  = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic     found;
        port_id_t port;
    } rr_pick_t;

    function automatic rr_pick_t rr_select(
        input logic [C_MAX_PORTS-1:0] eligible,
        input port_id_t               rr,
        input int                     num_ports
    );
        rr_pick_t pick;
        int       idx;
        pick = '0;
        for (int k = 0; k < C_MAX_PORTS; k++) begin
            idx = int'(rr) + k;
            if (idx >= num_ports) idx = idx - num_ports;
            if ((k < num_ports) && !pick.found && (idx < C_MAX_PORTS) &&
                eligible[idx[C_PORT_ID_W-1:0]]) begin
                pick.found = 1'b1;
                pick.port  = idx[C_PORT_ID_W-1:0];
            end
        end
        return pick;
    endfunction

endpackage
`default_nettype wire

// File: rtl/arb_tag_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : arb_tag_fifo
//  Purpose  : In-order FIFO of requester ids for outstanding SDRAM reads
//  Revision : 1.0 - initial release
// ============================================================================
module arb_tag_fifo
    import sdram_arb_pkg::*;
#(
    parameter int DEPTH = 8
)(
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_push,
    input  port_id_t                 i_push_id,
    input  logic                     i_pop,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count,
    output port_id_t                 o_head
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    port_id_t          r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              w_push;
    logic              w_pop;

    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_head  = r_mem[r_rd_ptr];
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_push_id;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + PTR_W'(1);
            if (w_pop)
                r_rd_ptr <= (r_rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/sdram_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : sdram_port_arbiter
//  Purpose  : Round-robin sharing of one SDRAM Avalon-MM slave between DMA
//             masters, with in-order routing of pipelined read returns
//  Revision : 1.0 - initial release
// ============================================================================
module sdram_port_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int NUM_PORTS   = 4,
    parameter int ADDR_W      = C_ADDR_W,
    parameter int DATA_W      = C_DATA_W,
    parameter int MAX_PENDING = 8,
    localparam int BE_W       = DATA_W / 8,
    localparam int CNT_W      = $clog2(MAX_PENDING) + 1
)(
    input  logic                        clk_clk,
    input  logic                        reset_n_reset_n,
    input  logic [NUM_PORTS*ADDR_W-1:0] req_address,
    input  logic [NUM_PORTS*BE_W-1:0]   req_byteenable,
    input  logic [NUM_PORTS*DATA_W-1:0] req_writedata,
    input  logic [NUM_PORTS-1:0]        req_read,
    input  logic [NUM_PORTS-1:0]        req_write,
    output logic [NUM_PORTS-1:0]        req_waitrequest,
    output logic [DATA_W-1:0]           req_readdata,
    output logic [NUM_PORTS-1:0]        req_readdatavalid,
    output logic [ADDR_W-1:0]           sdram_address,
    output logic [BE_W-1:0]             sdram_byteenable_n,
    output logic                        sdram_chipselect,
    output logic [DATA_W-1:0]           sdram_writedata,
    output logic                        sdram_read_n,
    output logic                        sdram_write_n,
    input  logic [DATA_W-1:0]           sdram_readdata,
    input  logic                        sdram_readdatavalid,
    input  logic                        sdram_waitrequest,
    output logic [CNT_W-1:0]            pending_count,
    output logic                        err_orphan
);

    arb_state_t              r_state, w_state_nxt;
    port_id_t                r_gnt, w_gnt_nxt;
    port_id_t                r_rr, w_rr_nxt;
    logic                    r_err_orphan;

    logic                    w_fifo_full, w_fifo_empty;
    logic                    w_push, w_pop;
    port_id_t                w_head;

    logic [NUM_PORTS-1:0]    w_eligible;
    logic [C_MAX_PORTS-1:0]  w_elig_ext;
    rr_pick_t                w_pick;

    logic                    w_sel_rd, w_sel_wr, w_cs, w_accept;
    logic [ADDR_W-1:0]       w_sel_addr;
    logic [BE_W-1:0]         w_sel_be;
    logic [DATA_W-1:0]       w_sel_wdata;

    assign w_eligible = req_write | (req_read & {NUM_PORTS{~w_fifo_full}});

    always_comb begin
        w_elig_ext                = '0;
        w_elig_ext[NUM_PORTS-1:0] = w_eligible;
        w_pick                    = rr_select(w_elig_ext, r_rr, NUM_PORTS);
    end

    always_comb begin
        w_sel_rd    = 1'b0;
        w_sel_wr    = 1'b0;
        w_sel_addr  = '0;
        w_sel_be    = '0;
        w_sel_wdata = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (r_gnt == port_id_t'(i)) begin
                w_sel_rd    = req_read[i];
                w_sel_wr    = req_write[i];
                w_sel_addr  = req_address[i*ADDR_W +: ADDR_W];
                w_sel_be    = req_byteenable[i*BE_W +: BE_W];
                w_sel_wdata = req_writedata[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_gnt_nxt       = r_gnt;
        w_rr_nxt        = r_rr;
        w_cs            = 1'b0;
        w_accept        = 1'b0;
        w_push          = 1'b0;
        req_waitrequest = '1;
        case (r_state)
            ST_IDLE: begin
                if (w_pick.found) begin
                    w_state_nxt = ST_OWN;
                    w_gnt_nxt   = w_pick.port;
                end
            end
            ST_OWN: begin
                w_cs = w_sel_rd | w_sel_wr;
                for (int i = 0; i < NUM_PORTS; i++) begin
                    if (r_gnt == port_id_t'(i)) req_waitrequest[i] = sdram_waitrequest;
                end
                w_accept = w_cs & ~sdram_waitrequest;
                // Write has priority; a simultaneous read stays pending for a later grant
                w_push   = w_accept & ~w_sel_wr;
                if (w_accept) begin
                    w_state_nxt = ST_IDLE;
                    w_rr_nxt    = (r_gnt == port_id_t'(NUM_PORTS - 1)) ? '0
                                                                       : r_gnt + port_id_t'(1);
                end else if (!w_cs) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign sdram_chipselect   = w_cs;
    assign sdram_read_n       = ~(w_cs & ~w_sel_wr);
    assign sdram_write_n      = ~(w_cs & w_sel_wr);
    assign sdram_address      = w_sel_addr;
    assign sdram_byteenable_n = ~w_sel_be;
    assign sdram_writedata    = w_sel_wdata;

    assign w_pop        = sdram_readdatavalid & ~w_fifo_empty;
    assign req_readdata = sdram_readdata;
    assign err_orphan   = r_err_orphan;

    always_comb begin
        req_readdatavalid = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            req_readdatavalid[i] = w_pop & (w_head == port_id_t'(i));
        end
    end

    always_ff @(posedge clk_clk or negedge reset_n_reset_n) begin
        if (!reset_n_reset_n) begin
            r_state      <= ST_IDLE;
            r_gnt        <= '0;
            r_rr         <= '0;
            r_err_orphan <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_rr    <= w_rr_nxt;
            if (sdram_readdatavalid & w_fifo_empty) r_err_orphan <= 1'b1;
        end
    end

    arb_tag_fifo #(
        .DEPTH      (MAX_PENDING)
    ) u_tag_fifo (
        .i_clk      (clk_clk),
        .i_rst_n    (reset_n_reset_n),
        .i_push     (w_push),
        .i_push_id  (r_gnt),
        .i_pop      (w_pop),
        .o_full     (w_fifo_full),
        .o_empty    (w_fifo_empty),
        .o_count    (pending_count),
        .o_head     (w_head)
    );

endmodule
`default_nettype wire

// File: tb/tb_sdram_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sdram_port_arbiter
//  Purpose  : Directed self-checking bench for sdram_port_arbiter
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sdram_port_arbiter;

    localparam int NP = 4;
    localparam int AW = 25;
    localparam int DW = 32;
    localparam int BW = DW / 8;
    localparam int MP = 8;
    localparam int CW = $clog2(MP) + 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [NP*AW-1:0] req_address;
    logic [NP*BW-1:0] req_byteenable;
    logic [NP*DW-1:0] req_writedata;
    logic [NP-1:0]    req_read;
    logic [NP-1:0]    req_write;
    logic [NP-1:0]    req_waitrequest;
    logic [DW-1:0]    req_readdata;
    logic [NP-1:0]    req_readdatavalid;
    logic [AW-1:0]    sdram_address;
    logic [BW-1:0]    sdram_byteenable_n;
    logic             sdram_chipselect;
    logic [DW-1:0]    sdram_writedata;
    logic             sdram_read_n;
    logic             sdram_write_n;
    logic [DW-1:0]    sdram_readdata;
    logic             sdram_readdatavalid;
    logic             sdram_waitrequest;
    logic [CW-1:0]    pending_count;
    logic             err_orphan;

    int n_vec = 0;
    int n_bad = 0;

    int exp_order [5] = '{0, 1, 2, 3, 0};
    int exp_drain [7] = '{2, 3, 0, 0, 0, 0, 0};
    int exp_il_p  [3] = '{3, 0, 3};
    logic [31:0] exp_il_d [3] = '{32'hA, 32'hB, 32'hC};

    always #5 clk = ~clk;

    sdram_port_arbiter #(
        .NUM_PORTS   (NP),
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .MAX_PENDING (MP)
    ) dut (
        .clk_clk             (clk),
        .reset_n_reset_n     (rst_n),
        .req_address         (req_address),
        .req_byteenable      (req_byteenable),
        .req_writedata       (req_writedata),
        .req_read            (req_read),
        .req_write           (req_write),
        .req_waitrequest     (req_waitrequest),
        .req_readdata        (req_readdata),
        .req_readdatavalid   (req_readdatavalid),
        .sdram_address       (sdram_address),
        .sdram_byteenable_n  (sdram_byteenable_n),
        .sdram_chipselect    (sdram_chipselect),
        .sdram_writedata     (sdram_writedata),
        .sdram_read_n        (sdram_read_n),
        .sdram_write_n       (sdram_write_n),
        .sdram_readdata      (sdram_readdata),
        .sdram_readdatavalid (sdram_readdatavalid),
        .sdram_waitrequest   (sdram_waitrequest),
        .pending_count       (pending_count),
        .err_orphan          (err_orphan)
    );

    task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int low_port(input logic [NP-1:0] wr);
        int p;
        p = -1;
        for (int i = NP - 1; i >= 0; i--) if (!wr[i]) p = i;
        return p;
    endfunction

    // Hold one request until the arbiter accepts it, then release after that edge
    task automatic do_xfer(input int p, input bit wr, input logic [AW-1:0] addr);
        bit done;
        done = 1'b0;
        req_address[p*AW +: AW] = addr;
        if (wr) req_write[p] = 1'b1;
        else    req_read[p]  = 1'b1;
        for (int c = 0; c < 16 && !done; c++) begin
            @(negedge clk);
            if (!req_waitrequest[p]) done = 1'b1;
        end
        check_vec($sformatf("xfer_accept_p%0d", p), 64'(done), 64'd1);
        @(posedge clk); #1;
        req_write[p] = 1'b0;
        req_read[p]  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cs_cycles, wn_cycles, wr_low, pulses, n_acc, blocked;
        bit prev_cs, found;

        rst_n = 1'b0;
        req_address = '0; req_byteenable = '0; req_writedata = '0;
        req_read = '0; req_write = '0;
        sdram_readdata = '0; sdram_readdatavalid = 1'b0; sdram_waitrequest = 1'b0;
        repeat (2) @(negedge clk);

        check_vec("rst_cs",      64'(sdram_chipselect),  64'd0);
        check_vec("rst_read_n",  64'(sdram_read_n),      64'd1);
        check_vec("rst_write_n", 64'(sdram_write_n),     64'd1);
        check_vec("rst_waitreq", 64'(req_waitrequest),   64'hF);
        check_vec("rst_rdv",     64'(req_readdatavalid), 64'd0);
        check_vec("rst_pending", 64'(pending_count),     64'd0);
        check_vec("rst_orphan",  64'(err_orphan),        64'd0);
        rst_n = 1'b1;

        // Single write on port 2, slave stalls three cycles
        req_address[2*AW +: AW]   = 25'h0001234;
        req_writedata[2*DW +: DW] = 32'hDEADBEEF;
        req_byteenable[2*BW +: BW] = 4'b0011;
        req_write[2] = 1'b1;
        cs_cycles = 0; wn_cycles = 0; wr_low = 0; pulses = 0; prev_cs = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (sdram_chipselect) cs_cycles++;
            sdram_waitrequest = (cs_cycles <= 3);
            #1;
            if (sdram_chipselect && !prev_cs) pulses++;
            prev_cs = sdram_chipselect;
            if (!sdram_write_n) wn_cycles++;
            if (req_waitrequest != 4'hF) begin
                wr_low++;
                check_vec("wr_addr",    64'(sdram_address),      64'h1234);
                check_vec("wr_data",    64'(sdram_writedata),    64'hDEADBEEF);
                check_vec("wr_be_n",    64'(sdram_byteenable_n), 64'hC);
                check_vec("wr_read_n",  64'(sdram_read_n),       64'd1);
                check_vec("wr_waitreq", 64'(req_waitrequest),    64'hB);
                @(posedge clk); #1;
                req_write[2] = 1'b0;
            end
        end
        sdram_waitrequest = 1'b0;
        check_vec("wr_cs_pulses",   64'(pulses),        64'd1);
        check_vec("wr_cs_cycles",   64'(cs_cycles),     64'd4);
        check_vec("wr_write_n_low", 64'(wn_cycles),     64'd4);
        check_vec("wr_waitreq_low", 64'(wr_low),        64'd1);
        check_vec("wr_pending",     64'(pending_count), 64'd0);

        // Fresh reset so the round-robin pointer starts at port 0
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;

        req_read = 4'hF;
        n_acc = 0;
        for (int c = 0; c < 40 && n_acc < 5; c++) begin
            @(negedge clk);
            if (req_waitrequest != 4'hF) begin
                check_vec($sformatf("rr_grant_%0d", n_acc),
                          64'(low_port(req_waitrequest)), 64'(exp_order[n_acc]));
                n_acc++;
                if (n_acc == 5) begin
                    @(posedge clk); #1;
                    req_read = '0;
                end
            end
        end
        check_vec("rr_accepts", 64'(n_acc), 64'd5);
        @(negedge clk);
        check_vec("rr_pending", 64'(pending_count), 64'd5);

        // Fill to MAX_PENDING, then a held read must stall while a write still gets through
        do_xfer(0, 1'b0, 25'h100);
        do_xfer(0, 1'b0, 25'h101);
        do_xfer(0, 1'b0, 25'h102);
        @(negedge clk);
        check_vec("full_pending", 64'(pending_count), 64'd8);
        req_read[0] = 1'b1;
        blocked = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (sdram_chipselect || !req_waitrequest[0]) blocked++;
        end
        check_vec("full_no_grant", 64'(blocked), 64'd0);
        req_writedata[1*DW +: DW] = 32'h5A5A0001;
        do_xfer(1, 1'b1, 25'h0000777);
        @(negedge clk);
        check_vec("full_after_wr", 64'(pending_count), 64'd8);

        // Pop frees one slot; the held read is then granted and accepted alongside another pop
        sdram_readdata = 32'h11; sdram_readdatavalid = 1'b1;
        #1;
        check_vec("pop1_rdv",  64'(req_readdatavalid), 64'h1);
        check_vec("pop1_data", 64'(req_readdata),      64'h11);
        @(posedge clk); #1;
        sdram_readdatavalid = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 10 && !found; c++) begin
            @(negedge clk);
            if (!req_waitrequest[0]) begin
                found = 1'b1;
                check_vec("pp_pending_before", 64'(pending_count), 64'd7);
                sdram_readdata = 32'h22; sdram_readdatavalid = 1'b1;
                #1;
                check_vec("pp_rdv", 64'(req_readdatavalid), 64'h2);
                @(posedge clk); #1;
                req_read[0] = 1'b0;
                sdram_readdatavalid = 1'b0;
            end
        end
        check_vec("pp_granted", 64'(found), 64'd1);
        @(negedge clk);
        check_vec("pp_pending_after", 64'(pending_count), 64'd7);

        // Drain remaining tags in issue order
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            sdram_readdata = 32'h100 + i; sdram_readdatavalid = 1'b1;
            #1;
            check_vec($sformatf("drain_rdv_%0d", i),  64'(req_readdatavalid), 64'(1 << exp_drain[i]));
            check_vec($sformatf("drain_data_%0d", i), 64'(req_readdata),      64'(32'h100 + i));
        end
        @(negedge clk);
        sdram_readdatavalid = 1'b0;
        #1;
        check_vec("drain_pending", 64'(pending_count), 64'd0);
        check_vec("drain_orphan",  64'(err_orphan),    64'd0);

        // Interleaved requesters 3,0,3
        do_xfer(3, 1'b0, 25'h300);
        do_xfer(0, 1'b0, 25'h000);
        do_xfer(3, 1'b0, 25'h301);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            sdram_readdata = exp_il_d[i]; sdram_readdatavalid = 1'b1;
            #1;
            check_vec($sformatf("il_rdv_%0d", i),  64'(req_readdatavalid), 64'(1 << exp_il_p[i]));
            check_vec($sformatf("il_data_%0d", i), 64'(req_readdata),      64'(exp_il_d[i]));
        end
        @(negedge clk);
        sdram_readdatavalid = 1'b0;
        #1;
        check_vec("il_pending", 64'(pending_count), 64'd0);

        // Spurious return with nothing outstanding
        @(negedge clk);
        sdram_readdata = 32'h55; sdram_readdatavalid = 1'b1;
        #1;
        check_vec("orphan_rdv", 64'(req_readdatavalid), 64'd0);
        @(negedge clk);
        sdram_readdatavalid = 1'b0;
        #1;
        check_vec("orphan_flag",    64'(err_orphan),    64'd1);
        check_vec("orphan_pending", 64'(pending_count), 64'd0);

        // Reset while a stalled read owns the bus with one read outstanding
        do_xfer(1, 1'b0, 25'h0000010);
        sdram_waitrequest = 1'b1;
        req_read[2] = 1'b1;
        repeat (2) @(negedge clk);
        check_vec("own_cs",      64'(sdram_chipselect), 64'd1);
        check_vec("own_read_n",  64'(sdram_read_n),     64'd0);
        check_vec("own_pending", 64'(pending_count),    64'd1);
        rst_n = 1'b0;
        #1;
        check_vec("mid_rst_cs",      64'(sdram_chipselect),  64'd0);
        check_vec("mid_rst_read_n",  64'(sdram_read_n),      64'd1);
        check_vec("mid_rst_write_n", 64'(sdram_write_n),     64'd1);
        check_vec("mid_rst_waitreq", 64'(req_waitrequest),   64'hF);
        check_vec("mid_rst_rdv",     64'(req_readdatavalid), 64'd0);
        check_vec("mid_rst_pending", 64'(pending_count),     64'd0);
        check_vec("mid_rst_orphan",  64'(err_orphan),        64'd0);
        req_read = '0;
        sdram_waitrequest = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
